ahb_mbus_bridge: RTL and testbench

//  AHB-Lite slave exposing an MBus node's TX/RX handshakes through a small register file

---
 rtl/ahb_mbus_bridge_if.sv | 61 ++++++
 rtl/ahb_mbus_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_ahb_mbus_bridge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mbus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_mbus_bridge_if
// Description : AHB-Lite slave bus plus MBus node TX/RX handshake signals
//               shared by the bridge and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_mbus_bridge_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NADDR_WIDTH = 8
);
  // AHB-Lite slave side
  logic                   HSEL;
  logic                   HWRITE;
  logic                   HREADY;
  logic [31:0]            HADDR;
  logic [31:0]            HWDATA;
  logic [2:0]             HSIZE;
  logic [1:0]             HTRANS;
  logic                   HREADYOUT;
  logic [1:0]             HRESP;
  logic [31:0]            HRDATA;
  // Node TX handshake
  logic [NADDR_WIDTH-1:0] ADDR_IN;
  logic [DATA_WIDTH-1:0]  DATA_IN;
  logic                   REQ_TX;
  logic                   ACK_TX;
  // Node RX handshake
  logic [NADDR_WIDTH-1:0] ADDR_OUT;
  logic [DATA_WIDTH-1:0]  DATA_OUT;
  logic                   REQ_RX;
  logic                   ACK_RX;
  // Misc
  logic                   ACK_RECEIVED;
  logic                   IRQ;

  // Bridge view
  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HWDATA, HSIZE, HTRANS,
    output HREADYOUT, HRESP, HRDATA,
    output ADDR_IN, DATA_IN, REQ_TX,
    input  ACK_TX,
    input  ADDR_OUT, DATA_OUT, REQ_RX,
    output ACK_RX,
    input  ACK_RECEIVED,
    output IRQ
  );

  // Environment view (CPU fabric plus node)
  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HWDATA, HSIZE, HTRANS,
    input  HREADYOUT, HRESP, HRDATA,
    input  ADDR_IN, DATA_IN, REQ_TX,
    output ACK_TX,
    output ADDR_OUT, DATA_OUT, REQ_RX,
    input  ACK_RX,
    output ACK_RECEIVED,
    input  IRQ
  );
endinterface
`default_nettype wire

// File: rtl/ahb_mbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb_mbus_bridge
// Description : Zero-wait-state AHB-Lite slave exposing an MBus node's TX/RX
//               4-phase handshakes through a small register file, with TX and
//               RX message FIFOs so the CPU never stalls on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_mbus_bridge #(
  parameter int DATA_WIDTH    = 32,
  parameter int NADDR_WIDTH   = 8,
  parameter int TX_DEPTH_LOG2 = 2,
  parameter int RX_DEPTH_LOG2 = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_mbus_bridge_if.slave bus
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_CW    = TX_DEPTH_LOG2 + 1;
  localparam int RX_CW    = RX_DEPTH_LOG2 + 1;

  localparam logic [TX_CW-1:0]         TX_CNT_FULL = TX_CW'(TX_DEPTH);
  localparam logic [TX_CW-1:0]         TX_CNT_ONE  = TX_CW'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1);
  localparam logic [RX_CW-1:0]         RX_CNT_FULL = RX_CW'(RX_DEPTH);
  localparam logic [RX_CW-1:0]         RX_CNT_ONE  = RX_CW'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1);

  // Register map, word index HADDR[4:2]
  localparam logic [2:0] REG_TXDATA  = 3'd0;
  localparam logic [2:0] REG_TXADDR  = 3'd1;
  localparam logic [2:0] REG_RXDATA  = 3'd2;
  localparam logic [2:0] REG_RXADDR  = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_FLAGCLR = 3'd5;
  localparam logic [2:0] REG_IRQEN   = 3'd6;

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_REL = 2'd2} tx_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                     addr_accept;
  logic                     rd_accept;
  logic [2:0]               addr_idx;
  logic                     dp_wr_q,  dp_wr_d;
  logic [2:0]               dp_idx_q, dp_idx_d;
  logic                     wr_txdata, wr_txaddr, wr_flagclr, wr_irqen;

  logic [NADDR_WIDTH-1:0]   txaddr_q,  txaddr_d;
  logic [6:0]               irq_en_q,  irq_en_d;
  logic                     ackrcv_q,  ackrcv_d;
  logic                     txovf_q,   txovf_d;
  logic                     rxunf_q,   rxunf_d;
  logic [2:0]               flag_clr;
  logic [31:0]              hrdata_q,  hrdata_d;
  logic [31:0]              rd_data;
  logic [31:0]              status;

  logic [NADDR_WIDTH-1:0]   tx_mem_addr [TX_DEPTH];
  logic [DATA_WIDTH-1:0]    tx_mem_data [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0]         tx_count_q, tx_count_d;
  logic                     tx_push, tx_pop, tx_full, tx_empty;

  logic [NADDR_WIDTH-1:0]   rx_mem_addr [RX_DEPTH];
  logic [DATA_WIDTH-1:0]    rx_mem_data [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0]         rx_count_q, rx_count_d;
  logic                     rx_push, rx_pop, rx_full, rx_empty;

  tx_state_t                tx_state_q, tx_state_d;
  logic                     req_tx_q,   req_tx_d;
  logic [NADDR_WIDTH-1:0]   addr_in_q,  addr_in_d;
  logic [DATA_WIDTH-1:0]    data_in_q,  data_in_d;

  rx_state_t                rx_state_q, rx_state_d;
  logic                     ack_rx_q,   ack_rx_d;

  // Address bits outside the decoded window are don't-care
  logic                     unused_ok;
  assign unused_ok = &{1'b0, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA};

  // --------------------------------------------------------------------------
  // AHB address/data phase decode
  // --------------------------------------------------------------------------
  assign addr_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & (bus.HSIZE == 3'b010);
  assign rd_accept   = addr_accept & ~bus.HWRITE;
  assign addr_idx    = bus.HADDR[4:2];

  assign dp_wr_d  = addr_accept & bus.HWRITE;
  assign dp_idx_d = addr_idx;

  // Writes take effect at the end of their data phase
  assign wr_txdata  = dp_wr_q & (dp_idx_q == REG_TXDATA);
  assign wr_txaddr  = dp_wr_q & (dp_idx_q == REG_TXADDR);
  assign wr_flagclr = dp_wr_q & (dp_idx_q == REG_FLAGCLR);
  assign wr_irqen   = dp_wr_q & (dp_idx_q == REG_IRQEN);

  // --------------------------------------------------------------------------
  // FIFO status
  // --------------------------------------------------------------------------
  assign tx_full  = (tx_count_q == TX_CNT_FULL);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_CNT_FULL);
  assign rx_empty = (rx_count_q == '0);

  // A full TX FIFO drops the word; TXOVF records the loss
  assign tx_push = wr_txdata & ~tx_full;
  // RXDATA pops at the accepted address-phase edge, together with HRDATA capture
  assign rx_pop  = rd_accept & (addr_idx == REG_RXDATA) & ~rx_empty;

  // Next TX FIFO pointers and occupancy; push+pop leaves the count unchanged
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_PTR_ONE;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_PTR_ONE;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase
  end

  // Next RX FIFO pointers and occupancy; push+pop leaves the count unchanged
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_PTR_ONE;
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_PTR_ONE;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
  end

  // FIFO storage needs no reset: occupancy alone defines valid entries
  always_ff @(posedge HCLK) begin
    if (tx_push) begin
      tx_mem_addr[tx_wr_ptr_q] <= txaddr_q;
      tx_mem_data[tx_wr_ptr_q] <= bus.HWDATA[DATA_WIDTH-1:0];
    end
    if (rx_push) begin
      rx_mem_addr[rx_wr_ptr_q] <= bus.ADDR_OUT;
      rx_mem_data[rx_wr_ptr_q] <= bus.DATA_OUT;
    end
  end

  // --------------------------------------------------------------------------
  // TX handshake FSM: one FIFO entry per 4-phase REQ/ACK cycle
  // --------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    req_tx_d   = req_tx_q;
    addr_in_d  = addr_in_q;
    data_in_d  = data_in_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty) begin
          addr_in_d  = tx_mem_addr[tx_rd_ptr_q];
          data_in_d  = tx_mem_data[tx_rd_ptr_q];
          req_tx_d   = 1'b1;
          tx_state_d = T_REQ;
        end
      end
      T_REQ: begin
        if (bus.ACK_TX) begin
          req_tx_d   = 1'b0;
          tx_pop     = 1'b1;
          tx_state_d = T_REL;
        end
      end
      T_REL: begin
        if (!bus.ACK_TX) tx_state_d = T_IDLE;
      end
      default: begin
        req_tx_d   = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // RX handshake FSM: withholding ACK_RX while full is the backpressure
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    ack_rx_d   = ack_rx_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (bus.REQ_RX && !rx_full) begin
          rx_push    = 1'b1;
          ack_rx_d   = 1'b1;
          rx_state_d = R_ACK;
        end
      end
      R_ACK: begin
        if (!bus.REQ_RX) begin
          ack_rx_d   = 1'b0;
          rx_state_d = R_IDLE;
        end
      end
      default: begin
        ack_rx_d   = 1'b0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  assign flag_clr = wr_flagclr ? bus.HWDATA[6:4] : 3'b000;

  // Sticky flags and writable registers; a set on the clear edge wins
  always_comb begin
    txaddr_d = wr_txaddr ? bus.HWDATA[NADDR_WIDTH-1:0] : txaddr_q;
    irq_en_d = wr_irqen  ? bus.HWDATA[6:0]             : irq_en_q;
    ackrcv_d = (ackrcv_q & ~flag_clr[0]) | bus.ACK_RECEIVED;
    txovf_d  = (txovf_q  & ~flag_clr[1]) | (wr_txdata & tx_full);
    rxunf_d  = (rxunf_q  & ~flag_clr[2]) |
               (rd_accept & (addr_idx == REG_RXDATA) & rx_empty);
  end

  // STATUS word assembled from live FIFO state and sticky flags
  always_comb begin
    status             = '0;
    status[0]          = ~rx_empty;
    status[1]          = rx_full;
    status[2]          = tx_empty;
    status[3]          = tx_full;
    status[4]          = ackrcv_q;
    status[5]          = txovf_q;
    status[6]          = rxunf_q;
    status[8 +: RX_CW]  = rx_count_q;
    status[16 +: TX_CW] = tx_count_q;
  end

  // Read mux; write-only and reserved registers read as zero
  always_comb begin
    rd_data = '0;
    case (addr_idx)
      REG_TXADDR: rd_data[NADDR_WIDTH-1:0] = txaddr_q;
      REG_RXDATA: if (!rx_empty) rd_data[DATA_WIDTH-1:0]  = rx_mem_data[rx_rd_ptr_q];
      REG_RXADDR: if (!rx_empty) rd_data[NADDR_WIDTH-1:0] = rx_mem_addr[rx_rd_ptr_q];
      REG_STATUS: rd_data = status;
      REG_IRQEN:  rd_data[6:0] = irq_en_q;
      default:    rd_data = '0;
    endcase
  end

  // HRDATA changes only on an accepted read
  assign hrdata_d = rd_accept ? rd_data : hrdata_q;

  // State register for bus decode, register file, FIFO pointers and both FSMs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_wr_q     <= 1'b0;
      dp_idx_q    <= 3'd0;
      txaddr_q    <= '0;
      irq_en_q    <= '0;
      ackrcv_q    <= 1'b0;
      txovf_q     <= 1'b0;
      rxunf_q     <= 1'b0;
      hrdata_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_state_q  <= T_IDLE;
      req_tx_q    <= 1'b0;
      addr_in_q   <= '0;
      data_in_q   <= '0;
      rx_state_q  <= R_IDLE;
      ack_rx_q    <= 1'b0;
    end else begin
      dp_wr_q     <= dp_wr_d;
      dp_idx_q    <= dp_idx_d;
      txaddr_q    <= txaddr_d;
      irq_en_q    <= irq_en_d;
      ackrcv_q    <= ackrcv_d;
      txovf_q     <= txovf_d;
      rxunf_q     <= rxunf_d;
      hrdata_q    <= hrdata_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_state_q  <= tx_state_d;
      req_tx_q    <= req_tx_d;
      addr_in_q   <= addr_in_d;
      data_in_q   <= data_in_d;
      rx_state_q  <= rx_state_d;
      ack_rx_q    <= ack_rx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 2'b00;
  assign bus.HRDATA    = hrdata_q;
  assign bus.ADDR_IN   = addr_in_q;
  assign bus.DATA_IN   = data_in_q;
  assign bus.REQ_TX    = req_tx_q;
  assign bus.ACK_RX    = ack_rx_q;
  assign bus.IRQ       = |(status[6:0] & irq_en_q);

endmodule
`default_nettype wire

// File: tb/tb_ahb_mbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_mbus_bridge
// Description : Directed self-checking bench for ahb_mbus_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_mbus_bridge;

  localparam logic [2:0] R_TXDATA  = 3'd0;
  localparam logic [2:0] R_TXADDR  = 3'd1;
  localparam logic [2:0] R_RXDATA  = 3'd2;
  localparam logic [2:0] R_RXADDR  = 3'd3;
  localparam logic [2:0] R_STATUS  = 3'd4;
  localparam logic [2:0] R_FLAGCLR = 3'd5;
  localparam logic [2:0] R_IRQEN   = 3'd6;
  localparam logic [2:0] R_RSVD    = 3'd7;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_assert = 0;
  int   n_fail   = 0;

  ahb_mbus_bridge_if #(.DATA_WIDTH(32), .NADDR_WIDTH(8)) bus ();

  ahb_mbus_bridge #(
    .DATA_WIDTH(32), .NADDR_WIDTH(8), .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus.slave)
  );

  always #5 HCLK = ~HCLK;

  // Hard stop if something wedges despite the bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write_sz(input logic [2:0] idx, input logic [31:0] data, input logic [2:0] sz);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
    bus.HADDR = {27'd0, idx, 2'b00}; bus.HSIZE = sz;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_write(input logic [2:0] idx, input logic [31:0] data);
    ahb_write_sz(idx, data, 3'b010);
  endtask

  task automatic ahb_read(input logic [2:0] idx, output logic [31:0] data);
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
    bus.HADDR = {27'd0, idx, 2'b00}; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    data = bus.HRDATA;
  endtask

  task automatic wait_req_tx(input logic val, input string tag);
    int n = 0;
    while (bus.REQ_TX !== val && n < 20) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk(tag, 32'(bus.REQ_TX), 32'(val));
  endtask

  task automatic wait_ack_rx(input logic val, input string tag);
    int n = 0;
    while (bus.ACK_RX !== val && n < 20) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk(tag, 32'(bus.ACK_RX), 32'(val));
  endtask

  initial begin
    logic [31:0] rd;
    HRESETn = 1'b0;
    bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.HADDR = '0;
    bus.HWDATA = '0; bus.HSIZE = 3'b010; bus.HTRANS = 2'b00;
    bus.ACK_TX = 1'b0; bus.ADDR_OUT = '0; bus.DATA_OUT = '0; bus.REQ_RX = 1'b0;
    bus.ACK_RECEIVED = 1'b0;

    // ---- 1: reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(bus.HRESP),     32'd0);
    chk("rst_req_tx",    32'(bus.REQ_TX),    32'd0);
    chk("rst_ack_rx",    32'(bus.ACK_RX),    32'd0);
    chk("rst_irq",       32'(bus.IRQ),       32'd0);
    chk("rst_hrdata",    bus.HRDATA,         32'd0);
    chk("rst_addr_in",   32'(bus.ADDR_IN),   32'd0);
    chk("rst_data_in",   bus.DATA_IN,        32'd0);
    HRESETn = 1'b1;
    ahb_read(R_STATUS, rd);
    chk("rst_status", rd, 32'h0000_0004);

    // ---- 2: single TX message
    ahb_write(R_TXADDR, 32'h0000_00ab);
    ahb_read(R_TXADDR, rd);
    chk("txaddr_rb", rd, 32'h0000_00ab);
    ahb_write_sz(R_TXADDR, 32'h0000_0055, 3'b000);
    ahb_read(R_TXADDR, rd);
    chk("byte_write_ignored", rd, 32'h0000_00ab);
    ahb_write(R_TXDATA, 32'h1234_5678);
    wait_req_tx(1'b1, "tx1_req");
    chk("tx1_addr_in", 32'(bus.ADDR_IN), 32'h0000_00ab);
    chk("tx1_data_in", bus.DATA_IN, 32'h1234_5678);
    repeat (3) @(posedge HCLK);
    #1;
    chk("tx1_data_hold", bus.DATA_IN, 32'h1234_5678);
    bus.ACK_TX = 1'b1;
    wait_req_tx(1'b0, "tx1_req_drop");
    bus.ACK_TX = 1'b0;
    ahb_read(R_STATUS, rd);
    chk("tx1_status_after", rd, 32'h0000_0004);

    // ---- 3: TX overflow with ACK_TX held low
    for (int i = 0; i < 5; i++) ahb_write(R_TXDATA, 32'hA0 + 32'(i));
    ahb_read(R_STATUS, rd);
    chk("txovf_status", rd, 32'h0004_0028);
    for (int i = 0; i < 4; i++) begin
      wait_req_tx(1'b1, "txq_req");
      chk("txq_data_in", bus.DATA_IN, 32'hA0 + 32'(i));
      chk("txq_addr_in", 32'(bus.ADDR_IN), 32'h0000_00ab);
      bus.ACK_TX = 1'b1;
      wait_req_tx(1'b0, "txq_req_drop");
      bus.ACK_TX = 1'b0;
    end
    repeat (10) @(posedge HCLK);
    #1;
    chk("txq_no_fifth_req", 32'(bus.REQ_TX), 32'd0);
    ahb_read(R_STATUS, rd);
    chk("txq_status_drained", rd, 32'h0000_0024);
    ahb_write(R_FLAGCLR, 32'h0000_0020);
    ahb_read(R_STATUS, rd);
    chk("txovf_cleared", rd, 32'h0000_0004);

    // ---- 4: RX backpressure
    for (int i = 1; i <= 5; i++) begin
      bus.ADDR_OUT = 8'h40 + 8'(i);
      bus.DATA_OUT = 32'(i);
      bus.REQ_RX   = 1'b1;
      if (i <= 4) begin
        wait_ack_rx(1'b1, "rx_ack");
        bus.REQ_RX = 1'b0;
        wait_ack_rx(1'b0, "rx_ack_drop");
      end
    end
    repeat (8) @(posedge HCLK);
    #1;
    chk("rx5_held_off", 32'(bus.ACK_RX), 32'd0);
    ahb_read(R_STATUS, rd);
    chk("rx_full_status", rd, 32'h0000_0407);
    ahb_read(R_RXADDR, rd);
    chk("rx_head_addr", rd, 32'h0000_0041);
    ahb_read(R_RXDATA, rd);
    chk("rx_pop1", rd, 32'd1);
    wait_ack_rx(1'b1, "rx5_ack");
    bus.REQ_RX = 1'b0;
    wait_ack_rx(1'b0, "rx5_ack_drop");
    for (int i = 2; i <= 5; i++) begin
      ahb_read(R_RXDATA, rd);
      chk("rx_pop_n", rd, 32'(i));
    end
    ahb_read(R_STATUS, rd);
    chk("rx_empty_status", rd, 32'h0000_0004);

    // ---- 5: IRQ, underflow, flag clear
    ahb_write(R_IRQEN, 32'h0000_0001);
    chk("irq_idle", 32'(bus.IRQ), 32'd0);
    bus.ADDR_OUT = 8'h33; bus.DATA_OUT = 32'h77; bus.REQ_RX = 1'b1;
    wait_ack_rx(1'b1, "irq_rx_ack");
    bus.REQ_RX = 1'b0;
    wait_ack_rx(1'b0, "irq_rx_ack_drop");
    chk("irq_set", 32'(bus.IRQ), 32'd1);
    ahb_read(R_IRQEN, rd);
    chk("irq_en_rb", rd, 32'h0000_0001);
    ahb_read(R_RXDATA, rd);
    chk("irq_rxdata", rd, 32'h0000_0077);
    chk("irq_clr_on_pop", 32'(bus.IRQ), 32'd0);
    ahb_read(R_RXDATA, rd);
    chk("rxunf_data", rd, 32'd0);
    ahb_read(R_STATUS, rd);
    chk("rxunf_status", rd, 32'h0000_0044);
    ahb_write(R_FLAGCLR, 32'h0000_0040);
    ahb_read(R_STATUS, rd);
    chk("rxunf_cleared", rd, 32'h0000_0004);
    @(posedge HCLK); #1;
    bus.ACK_RECEIVED = 1'b1;
    @(posedge HCLK); #1;
    bus.ACK_RECEIVED = 1'b0;
    ahb_read(R_STATUS, rd);
    chk("ackrcv_status", rd, 32'h0000_0014);
    ahb_write(R_IRQEN, 32'h0000_0010);
    chk("ackrcv_irq", 32'(bus.IRQ), 32'd1);
    ahb_write(R_FLAGCLR, 32'h0000_0010);
    chk("ackrcv_irq_clr", 32'(bus.IRQ), 32'd0);
    // FLAGCLR and ACK_RECEIVED on the same edge: the set survives
    @(posedge HCLK); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
    bus.HADDR = {27'd0, R_FLAGCLR, 2'b00}; bus.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HWDATA = 32'h0000_0010; bus.ACK_RECEIVED = 1'b1;
    @(posedge HCLK); #1;
    bus.ACK_RECEIVED = 1'b0;
    ahb_read(R_STATUS, rd);
    chk("set_wins_clear", rd, 32'h0000_0014);
    ahb_write(R_FLAGCLR, 32'h0000_0010);
    ahb_read(R_RSVD, rd);
    chk("reserved_reads0", rd, 32'd0);
    ahb_read(R_TXDATA, rd);
    chk("wo_reads0", rd, 32'd0);

    // ---- 6: reset mid-handshake
    ahb_write(R_TXDATA, 32'h0000_dead);
    ahb_write(R_TXDATA, 32'h0000_beef);
    wait_req_tx(1'b1, "arst_req_up");
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_req_tx", 32'(bus.REQ_TX), 32'd0);
    chk("arst_addr_in", 32'(bus.ADDR_IN), 32'd0);
    chk("arst_data_in", bus.DATA_IN, 32'd0);
    chk("arst_irq", 32'(bus.IRQ), 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (5) @(posedge HCLK);
    #1;
    chk("arst_no_req_after", 32'(bus.REQ_TX), 32'd0);
    ahb_read(R_STATUS, rd);
    chk("arst_status", rd, 32'h0000_0004);
    ahb_read(R_TXADDR, rd);
    chk("arst_txaddr", rd, 32'd0);
    ahb_write(R_TXDATA, 32'h0000_5a5a);
    wait_req_tx(1'b1, "arst_restart_req");
    chk("arst_restart_data", bus.DATA_IN, 32'h0000_5a5a);
    chk("arst_restart_addr", 32'(bus.ADDR_IN), 32'd0);
    bus.ACK_TX = 1'b1;
    wait_req_tx(1'b0, "arst_restart_drop");
    bus.ACK_TX = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
